// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte stream to 32-bit instruction word writer for the instruction memory
// Optional inter-byte idle timeout enabled with `define LOADER_TIMEOUT_EN.
module instr_mem_loader #(
    parameter int NBITS   = 32,
    parameter int CELDAS  = 60,
    parameter int TIMEOUT = 1000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_wr_en,
    output logic [NBITS-1:0] o_wr_addr,
    output logic [NBITS-1:0] o_wr_data,
    output logic             o_loading,
    output logic             o_done,
    output logic             o_error,
    output logic [NBITS-1:0] o_word_count
);

    localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(((CELDAS - 4) / 4) * 4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      shift_q, shift_d;
    logic             wr_en_q, wr_en_d;
    logic [NBITS-1:0] wr_addr_q, wr_addr_d;
    logic [NBITS-1:0] wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [NBITS-1:0] count_q, count_d;
    logic [31:0]      word_w;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_q, idle_d;
`endif

    assign word_w = {shift_q, i_byte};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        error_d   = error_q;
        count_d   = count_q;
`ifdef LOADER_TIMEOUT_EN
        idle_d    = idle_q;
`endif
        // Start takes priority in every state, so a colliding byte is dropped.
        if (i_start) begin
            state_d = ST_LOAD;
            addr_d  = '0;
            idx_d   = '0;
            shift_d = '0;
            count_d = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_d  = '0;
`endif
        end else if (state_q == ST_LOAD) begin
            if (i_byte_valid) begin
`ifdef LOADER_TIMEOUT_EN
                idle_d = '0;
`endif
                if (idx_q == 2'd3) begin
                    idx_d   = '0;
                    shift_d = '0;
                    if (addr_q > LAST_ADDR) begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = NBITS'(word_w);
                        addr_d    = addr_q + NBITS'(4);
                        count_d   = count_q + NBITS'(1);
                        if (word_w == 32'hFFFF_FFFF) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    idx_d   = idx_q + 2'd1;
                    shift_d = word_w[23:0];
                end
            end
`ifdef LOADER_TIMEOUT_EN
            else if (idx_q != 2'd0) begin
                if (idle_q == TW'(TIMEOUT - 1)) begin
                    idle_d  = '0;
                    idx_d   = '0;
                    shift_d = '0;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
`ifdef LOADER_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            count_q   <= count_d;
`ifdef LOADER_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_loading    = (state_q == ST_LOAD);
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    localparam int NBITS   = 32;
    localparam int CELDAS  = 60;
    localparam int TIMEOUT = 10;
    localparam int LAST    = ((CELDAS - 4) / 4) * 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       bval = 8'h00;
    logic             bvalid = 1'b0;
    logic             wr_en, loading, done, error;
    logic [NBITS-1:0] wr_addr, wr_data, word_count;

    instr_mem_loader #(.NBITS(NBITS), .CELDAS(CELDAS), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_byte       (bval),
        .i_byte_valid (bvalid),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_loading    (loading),
        .o_done       (done),
        .o_error      (error),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic        exp_done, exp_err;
    int          exp_cnt;
    logic [7:0]  bq[$];

    always @(negedge clk) if (wr_en) wr_q.push_back({wr_addr, wr_data});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bval = b;
        bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Reference: bytes group into words; word k goes to 4k unless 4k is past the last slot.
    task automatic model();
        logic [31:0] w;
        int a;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_cnt  = 0;
        for (int k = 0; 4 * k + 3 < bq.size(); k++) begin
            w = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
            a = 4 * k;
            if (a > LAST) begin
                exp_err = 1;
                break;
            end
            exp_q.push_back({32'(a), w});
            exp_cnt++;
            if (w == 32'hFFFF_FFFF) begin
                exp_done = 1;
                break;
            end
        end
    endtask

    task automatic run(input string name, input int max_gap);
        wr_q.delete();
        pulse_start();
        foreach (bq[i]) begin
            send_byte(bq[i]);
            repeat ($urandom_range(max_gap, 0)) cyc();
        end
        repeat (3) cyc();
        model();
        chk({name, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", name, i), wr_q[i], exp_q[i]);
        chk({name, "_done"}, 64'(done), 64'(exp_done));
        chk({name, "_err"}, 64'(error), 64'(exp_err));
        chk({name, "_cnt"}, 64'(word_count), 64'(exp_cnt));
        chk({name, "_loading"}, 64'(loading), 64'(!(exp_done || exp_err)));
    endtask

    typedef struct {
        logic [7:0]  b[8];
        int          nb;
        int          nwr;
        logic [31:0] d0;
        logic        dn;
        logic        er;
        int          cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{'{8'h20, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8, 2, 32'h2001_0002, 1'b1, 1'b0, 2};
        vecs[1] = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        vecs[2] = '{'{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00, 8'h00, 8'h00}, 5, 1, 32'h1234_5678, 1'b0, 1'b0, 1};
        vecs[3] = '{'{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFE}, 8, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};

        #2;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_outs", {wr_addr, wr_data}, 64'd0);
        chk("rst_flags", 64'({loading, done, error}), 64'd0);
        chk("rst_cnt", 64'(word_count), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Table vectors
        foreach (vecs[v]) begin
            bq.delete();
            for (int i = 0; i < vecs[v].nb; i++) bq.push_back(vecs[v].b[i]);
            run($sformatf("vec%0d", v), 0);
            chk($sformatf("vec%0d_tnwr", v), 64'(wr_q.size()), 64'(vecs[v].nwr));
            if (wr_q.size() > 0) chk($sformatf("vec%0d_td0", v), wr_q[0], {32'd0, vecs[v].d0});
            chk($sformatf("vec%0d_tflags", v), 64'({done, error}), 64'({vecs[v].dn, vecs[v].er}));
            chk($sformatf("vec%0d_tcnt", v), 64'(word_count), 64'(vecs[v].cnt));
        end
        chk("basic_addr1", (wr_q.size() > 1) ? 64'(1) : 64'(0), 64'(1));

        // Write latency and DONE ignoring bytes
        wr_q.delete();
        pulse_start();
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        chk("lat_we_n1", 64'(wr_en), 64'd1);
        chk("lat_done_n1", 64'({done, loading}), 64'b10);
        cyc();
        chk("lat_we_n2", 64'(wr_en), 64'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        repeat (3) cyc();
        chk("done_ignore_nwr", 64'(wr_q.size()), 64'd1);
        chk("done_ignore_cnt", 64'(word_count), 64'd1);

        // Overflow: 15 fitting words then a 16th
        bq.delete();
        for (int w = 0; w < 16; w++) begin
            bq.push_back(8'h01); bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'(w));
        end
        run("ovf", 0);
        chk("ovf_nwr15", 64'(wr_q.size()), 64'd15);
        if (wr_q.size() == 15) chk("ovf_last_addr", 64'(wr_q[14][63:32]), 64'd56);
        chk("ovf_flags", 64'({done, error}), 64'b01);

        // Restart mid-word
        wr_q.delete();
        pulse_start();
        send_byte(8'h11); send_byte(8'h22);
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        repeat (3) cyc();
        chk("restart_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("restart_wr", wr_q[0], {32'd0, 32'hAABB_CCDD});

        // Start collides with a valid byte
        wr_q.delete();
        start = 1'b1; bval = 8'h55; bvalid = 1'b1;
        cyc();
        start = 1'b0; bvalid = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        repeat (3) cyc();
        chk("coll_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("coll_wr", wr_q[0], {32'd0, 32'h0102_0304});

        // Idle gap inside a word
        wr_q.delete();
        pulse_start();
        send_byte(8'hAB);
        repeat (10) cyc();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (3) cyc();
`ifdef LOADER_TIMEOUT_EN
        chk("tmo_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("tmo_wr", wr_q[0], {32'd0, 32'h1122_3344});
`else
        chk("tmo_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) chk("tmo_wr", wr_q[0], {32'd0, 32'hAB11_2233});
`endif

        // Asynchronous reset after 3 bytes
        wr_q.delete();
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        #2 rst = 1'b1;
        #1;
        chk("mrst_outs", {wr_addr, wr_data}, 64'd0);
        chk("mrst_flags", 64'({wr_en, loading, done, error}), 64'd0);
        chk("mrst_cnt", 64'(word_count), 64'd0);
        cyc();
        rst = 1'b0;
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
        repeat (3) cyc();
        chk("mrst_idle_nwr", 64'(wr_q.size()), 64'd0);
        chk("mrst_idle_loading", 64'(loading), 64'd0);

        // Randomized loads against the reference model
        for (int r = 0; r < 25; r++) begin
            int nw;
            bq.delete();
            nw = $urandom_range(18, 0);
            for (int w = 0; w < nw; w++) begin
                logic [31:0] word;
                word = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
                for (int k = 3; k >= 0; k--) bq.push_back(word[8*k +: 8]);
            end
            for (int p = 0; p < $urandom_range(3, 0); p++) bq.push_back(8'($urandom));
            run($sformatf("rnd%0d", r), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side companion of the instruction memory. Receives a byte stream from the debug/UART path, assembles bytes MSB-first into 32-bit instruction words, and writes them to consecutive word slots of the byte-addressed instruction memory (addresses 0, 4, 8, ...). Loading stops when the all-ones HALT word has been written, or on overflow. The block sits between the debug unit's receive path and the memory's write port.

## Interface
- NBITS, 32: instruction word and address width.
- CELDAS, 60: instruction memory depth in address units; the last legal word address is the largest multiple of 4 that is ≤ CELDAS-4.
- TIMEOUT, 1000: inter-byte idle limit in cycles; used only with LOADER_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock; everything is on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse; begins a new load at address 0.
- i_byte  in  8  received byte.
- i_byte_valid  in  1  qualifies i_byte for exactly one cycle.
- o_wr_en  out  1  one-cycle write strobe to the instruction memory.
- o_wr_addr  out  NBITS  byte address of the word being written.
- o_wr_data  out  NBITS  assembled instruction word.
- o_loading  out  1  high while in LOAD.
- o_done  out  1  high in DONE after a HALT word has been written.
- o_error  out  1  high in DONE after an overflow; sticky until i_start or reset.
- o_word_count  out  NBITS  number of words written in the current load.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE: i_start moves to LOAD and clears the address, byte index, count, o_done and o_error. Bytes are ignored.
- LOAD: each cycle with i_byte_valid shifts the byte into the shift register, MSB first. The first byte received lands in bits 31:24.
- On the 4th byte, the block registers a write:
  - o_wr_data is the full word; o_wr_addr is the current address.
  - o_wr_en pulses on the next cycle.
  - The address then advances by 4, o_word_count increments, and the byte index wraps to 0.
- HALT: when the completed word equals 32'hFFFFFFFF, it is still written. The FSM then goes to DONE with o_done=1.
- Overflow: a 4th byte that arrives when the current address exceeds the last legal word address is not written (no o_wr_en). The FSM goes to DONE with o_error=1 and o_done=0.
- DONE: bytes are ignored. i_start behaves exactly as it does in IDLE.
- i_start during LOAD restarts the load: the partial word is discarded and the address returns to 0. If i_start and i_byte_valid occur in the same cycle, i_start wins and the byte is dropped.
- Address arithmetic is NBITS wide and unsigned; there is no wrap, because overflow stops the load first.

## Timing
- Reset values of all outputs: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_loading=0, o_done=0, o_error=0, o_word_count=0. The FSM is in IDLE.
- Latency: the 4th byte is sampled at edge N; o_wr_en is high during cycle N+1 only, with o_wr_addr and o_wr_data stable in that same cycle.
- Back-to-back valid bytes are accepted every cycle, giving a maximum of one write per 4 cycles.
- o_done and o_error assert in the same cycle as the final o_wr_en (HALT case) or the overflow decision.
- An asynchronous reset in the middle of a word discards the partial word immediately. No write is issued.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - An idle counter runs in LOAD while the byte index is non-zero. It clears on every accepted byte.
  - When it reaches TIMEOUT, the partial word is discarded, the byte index returns to 0, and the address is unchanged. The FSM stays in LOAD.
- LOADER_TIMEOUT_EN undefined: there is no counter, and a partial word waits indefinitely.

## Test plan
- Basic load: reset, i_start, then bytes 20,01,00,02 followed by FF,FF,FF,FF.
  - Required: write of 0x20010002 at address 0, then 0xFFFFFFFF at address 4.
  - o_done=1, o_word_count=2, o_error=0.
- Overflow: with CELDAS=60, send 15 non-HALT words and then a 16th.
  - Required: writes at addresses 0..56; no write for the 16th word; o_error=1, o_done=0.
- Restart: send 2 bytes, then pulse i_start, then 4 bytes AA,BB,CC,DD.
  - Required: a single write of 0xAABBCCDD at address 0.
- Collision: i_start in the same cycle as i_byte_valid.
  - Required: the byte is dropped and the next 4 bytes form the word at address 0.
- Mid-word reset: assert i_reset after 3 bytes.
  - Required: no o_wr_en; all outputs return to reset values; the FSM is in IDLE.
- LOADER_TIMEOUT_EN with TIMEOUT=10: send 1 byte, idle 10 cycles, then send 11,22,33,44.
  - Required: write of 0x11223344 at address 0.
